// File: rtl/datapath_pkg.sv
// Shared datapath definitions for the frame-based pipeline stages.
// Provides the default frame length, register-file geometry and the
// index/word types used by the register file and its neighbours.
package datapath_pkg;

    localparam int PHASES_DEFAULT = 10;
    localparam int REG_IDX_W      = 5;
    localparam int DATA_W         = 32;
    localparam int ZERO_REG       = 0;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0]    word_t;

endpackage

// File: rtl/frame_phase_counter.sv
// Modulo-PHASES frame phase counter shared by all frame-based stages so
// their phases stay aligned.
// Ports:
//   clock           in   rising-edge system clock
//   reset           in   asynchronous active-low clear
//   phase           out  current phase, 0..PHASES-1
//   is_read_phase   out  high while phase == READ_PHASE
//   is_write_phase  out  high while phase == WRITE_PHASE
module frame_phase_counter
    import datapath_pkg::*;
#(
    parameter int PHASES      = PHASES_DEFAULT,
    parameter int READ_PHASE  = 1,
    parameter int WRITE_PHASE = 0
) (
    input  logic       clock,
    input  logic       reset,
    output logic [3:0] phase,
    output logic       is_read_phase,
    output logic       is_write_phase
);

    // The phase output is 4 bits wide, so the frame cannot exceed 16 cycles.
    if (PHASES < 2 || PHASES > 16) begin : g_bad_phases
        $fatal(1, "frame_phase_counter: PHASES must be in 2..16");
    end

    logic [3:0] phase_q;
    logic [3:0] phase_d;

    // Wrap explicitly at PHASES-1 so the counter never leaves the frame.
    always_comb begin
        phase_d = phase_q + 4'd1;
        if (phase_q == 4'(PHASES - 1)) begin
            phase_d = 4'd0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            phase_q <= 4'd0;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign phase          = phase_q;
    assign is_read_phase  = (phase_q == 4'(READ_PHASE));
    assign is_write_phase = (phase_q == 4'(WRITE_PHASE));

endmodule

// File: rtl/register_file_wb.sv
// Architectural register file (NREGS x 32 bit, two read ports, one write
// port) running on the fixed multi-cycle instruction frame. Write-back
// data commits at WRITE_PHASE, operands are captured at READ_PHASE and
// held for the rest of the frame.
// Ports:
//   clock      in   rising-edge system clock
//   reset      in   asynchronous active-low reset
//   regWrite   in   write enable, sampled only at WRITE_PHASE
//   readReg1   in   rs index
//   readReg2   in   rt index
//   writeReg   in   destination index
//   writeData  in   write-back value
//   readData1  out  registered operand A
//   readData2  out  registered operand B
//   phase      out  current frame phase
//   wrDone     out  one-cycle pulse after a committed write
module register_file_wb
    import datapath_pkg::*;
#(
    parameter int PHASES      = PHASES_DEFAULT,
    parameter int READ_PHASE  = 1,
    parameter int WRITE_PHASE = 0,
    parameter int NREGS       = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        regWrite,
    input  logic [4:0]  readReg1,
    input  logic [4:0]  readReg2,
    input  logic [4:0]  writeReg,
    input  logic [31:0] writeData,
    output logic [31:0] readData1,
    output logic [31:0] readData2,
    output logic [3:0]  phase,
    output logic        wrDone
);

    if (READ_PHASE < 0 || READ_PHASE >= PHASES) begin : g_bad_read
        $fatal(1, "register_file_wb: READ_PHASE must be < PHASES");
    end
    if (WRITE_PHASE < 0 || WRITE_PHASE >= PHASES) begin : g_bad_write
        $fatal(1, "register_file_wb: WRITE_PHASE must be < PHASES");
    end
    if (NREGS < 2 || NREGS > 32) begin : g_bad_nregs
        $fatal(1, "register_file_wb: NREGS must be in 2..32");
    end

    // A same-edge bypass is only meaningful when read and write share a phase.
    localparam bit BYPASS = (READ_PHASE == WRITE_PHASE);

    logic  isReadPhase;
    logic  isWritePhase;
    logic  commit;
    word_t regs_q [NREGS];
    word_t rd1_q, rd1_d;
    word_t rd2_q, rd2_d;
    logic  wrDone_q;

    frame_phase_counter #(
        .PHASES      (PHASES),
        .READ_PHASE  (READ_PHASE),
        .WRITE_PHASE (WRITE_PHASE)
    ) u_phase (
        .clock          (clock),
        .reset          (reset),
        .phase          (phase),
        .is_read_phase  (isReadPhase),
        .is_write_phase (isWritePhase)
    );

    // Register 0 and indices beyond the implemented array read as zero.
    function automatic word_t lookup(input reg_idx_t idx, input word_t mem [NREGS]);
        word_t value;
        value = '0;
        if (idx != reg_idx_t'(ZERO_REG) && int'(idx) < NREGS) begin
            value = mem[idx];
        end
        return value;
    endfunction

    // Writes to register 0 (or past the array) are dropped and do not pulse wrDone.
    assign commit = isWritePhase && regWrite && (writeReg != reg_idx_t'(ZERO_REG))
                    && (int'(writeReg) < NREGS);

    // Operand capture; a committing write to the same index is forwarded
    // when both happen on one edge.
    always_comb begin
        rd1_d = rd1_q;
        rd2_d = rd2_q;
        if (isReadPhase) begin
            rd1_d = lookup(readReg1, regs_q);
            rd2_d = lookup(readReg2, regs_q);
            if (BYPASS && commit && readReg1 == writeReg) begin
                rd1_d = writeData;
            end
            if (BYPASS && commit && readReg2 == writeReg) begin
                rd2_d = writeData;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            rd1_q    <= '0;
            rd2_q    <= '0;
            wrDone_q <= 1'b0;
        end else begin
            if (commit) begin
                regs_q[writeReg] <= writeData;
            end
            rd1_q    <= rd1_d;
            rd2_q    <= rd2_d;
            wrDone_q <= commit;
        end
    end

    assign readData1 = rd1_q;
    assign readData2 = rd2_q;
    assign wrDone    = wrDone_q;

endmodule

// File: tb/tb_register_file_wb.sv
// Self-checking bench for register_file_wb: a default-configured instance
// and a same-phase (bypass) instance share all inputs and are compared
// each cycle against a behavioural model of the frame-based register file.
module tb_register_file_wb;

    localparam int PH = 10;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        regWrite = 1'b0;
    logic [4:0]  readReg1 = '0;
    logic [4:0]  readReg2 = '0;
    logic [4:0]  writeReg = '0;
    logic [31:0] writeData = '0;

    logic [31:0] rdA1, rdA2, rdB1, rdB2;
    logic [3:0]  phaseA, phaseB;
    logic        wrDoneA, wrDoneB;

    int testCount = 0;
    int failCount = 0;

    // Model state: index 0 = default config, index 1 = bypass config.
    logic [31:0] modelMem [2][32];
    int          modelPhase;
    logic [31:0] expRd1 [2];
    logic [31:0] expRd2 [2];
    logic        expWrDone [2];
    int          readPh  [2] = '{1, 0};
    int          writePh [2] = '{0, 0};

    register_file_wb dutA (
        .clock(clock), .reset(reset), .regWrite(regWrite),
        .readReg1(readReg1), .readReg2(readReg2), .writeReg(writeReg),
        .writeData(writeData), .readData1(rdA1), .readData2(rdA2),
        .phase(phaseA), .wrDone(wrDoneA)
    );

    register_file_wb #(.READ_PHASE(0), .WRITE_PHASE(0)) dutB (
        .clock(clock), .reset(reset), .regWrite(regWrite),
        .readReg1(readReg1), .readReg2(readReg2), .writeReg(writeReg),
        .writeData(writeData), .readData1(rdB1), .readData2(rdB2),
        .phase(phaseB), .wrDone(wrDoneB)
    );

    always #5 clock = ~clock;

    task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic void modelReset();
        for (int c = 0; c < 2; c++) begin
            for (int r = 0; r < 32; r++) modelMem[c][r] = '0;
            expRd1[c] = '0;
            expRd2[c] = '0;
            expWrDone[c] = 1'b0;
        end
        modelPhase = 0;
    endfunction

    // One rising edge of the architectural behaviour: write first so a read
    // on the same edge observes the newly written value.
    function automatic void modelEdge();
        for (int c = 0; c < 2; c++) begin
            expWrDone[c] = 1'b0;
            if (modelPhase == writePh[c] && regWrite && writeReg != 0) begin
                modelMem[c][writeReg] = writeData;
                expWrDone[c] = 1'b1;
            end
            if (modelPhase == readPh[c]) begin
                expRd1[c] = (readReg1 == 0) ? 32'd0 : modelMem[c][readReg1];
                expRd2[c] = (readReg2 == 0) ? 32'd0 : modelMem[c][readReg2];
            end
        end
        modelPhase = (modelPhase + 1) % PH;
    endfunction

    task automatic checkOutput();
        checkVal("A.phase", {28'd0, phaseA}, 32'(modelPhase));
        checkVal("B.phase", {28'd0, phaseB}, 32'(modelPhase));
        checkVal("A.wrDone", {31'd0, wrDoneA}, {31'd0, expWrDone[0]});
        checkVal("B.wrDone", {31'd0, wrDoneB}, {31'd0, expWrDone[1]});
        checkVal("A.readData1", rdA1, expRd1[0]);
        checkVal("A.readData2", rdA2, expRd2[0]);
        checkVal("B.readData1", rdB1, expRd1[1]);
        checkVal("B.readData2", rdB2, expRd2[1]);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkVal({tag, ".A.rd1"}, rdA1, 32'd0);
        checkVal({tag, ".A.rd2"}, rdA2, 32'd0);
        checkVal({tag, ".A.phase"}, {28'd0, phaseA}, 32'd0);
        checkVal({tag, ".A.wrDone"}, {31'd0, wrDoneA}, 32'd0);
        checkVal({tag, ".B.rd1"}, rdB1, 32'd0);
        checkVal({tag, ".B.rd2"}, rdB2, 32'd0);
        checkVal({tag, ".B.phase"}, {28'd0, phaseB}, 32'd0);
        checkVal({tag, ".B.wrDone"}, {31'd0, wrDoneB}, 32'd0);
    endtask

    // Drive one cycle of inputs, advance past the edge and compare.
    task automatic applyStimulus(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                                 input logic [4:0] r1, input logic [4:0] r2);
        regWrite  = we;
        writeReg  = wr;
        writeData = wd;
        readReg1  = r1;
        readReg2  = r2;
        @(posedge clock);
        modelEdge();
        #1;
        checkOutput();
    endtask

    task automatic runFrame(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                            input logic [4:0] r1, input logic [4:0] r2);
        for (int p = 0; p < PH; p++) applyStimulus(we, wr, wd, r1, r2);
    endtask

    initial begin
        modelReset();
        #2;
        checkResetOutputs("power_on_reset");
        @(posedge clock);
        #1;
        reset = 1'b1;

        // Basic write of reg 8, then read it back.
        runFrame(1'b1, 5'd8, 32'hDEADBEEF, 5'd0, 5'd0);
        runFrame(1'b0, 5'd0, 32'd0, 5'd8, 5'd0);
        checkVal("basic_rd1", rdA1, 32'hDEADBEEF);

        // Write request present only in phases 2..9 must be ignored.
        for (int p = 0; p < PH; p++)
            applyStimulus(p >= 2, 5'd9, 32'h12345678, 5'd9, 5'd9);
        runFrame(1'b0, 5'd0, 32'd0, 5'd9, 5'd9);
        checkVal("offphase_rd1", rdA1, 32'd0);

        // Register 0 cannot be written.
        runFrame(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
        runFrame(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        checkVal("zero_rd1", rdA1, 32'd0);
        checkVal("zero_rd2", rdA2, 32'd0);

        // Dual read, including both ports on the same register.
        runFrame(1'b1, 5'd3, 32'h00000011, 5'd0, 5'd0);
        runFrame(1'b1, 5'd4, 32'h00000022, 5'd3, 5'd4);
        checkVal("dual_rd1", rdA1, 32'h00000011);
        checkVal("dual_rd2", rdA2, 32'h00000022);
        runFrame(1'b0, 5'd0, 32'd0, 5'd4, 5'd4);
        checkVal("same_rd1", rdA1, 32'h00000022);
        checkVal("same_rd2", rdA2, 32'h00000022);

        // Same-edge forwarding in the bypass instance.
        applyStimulus(1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd0);
        checkVal("bypass_rd1", rdB1, 32'hA5A5A5A5);
        for (int p = 1; p < PH; p++) applyStimulus(1'b0, 5'd0, 32'd0, 5'd7, 5'd0);

        // Preload reg 5, then randomized traffic over a small index range.
        runFrame(1'b1, 5'd5, 32'hCAFEF00D, 5'd5, 5'd0);
        for (int i = 0; i < 300; i++)
            applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        runFrame(1'b1, 5'd5, 32'h0BADC0DE, 5'd5, 5'd5);

        // Mid-frame asynchronous reset with a write pending.
        for (int p = 0; p < 4; p++) applyStimulus(1'b1, 5'd6, 32'h55AA55AA, 5'd5, 5'd6);
        #2;
        reset = 1'b0;
        #1;
        checkResetOutputs("midframe_reset");
        modelReset();
        @(posedge clock);
        #1;
        checkResetOutputs("reset_held");
        reset = 1'b1;
        runFrame(1'b0, 5'd0, 32'd0, 5'd5, 5'd6);
        checkVal("post_reset_rd1", rdA1, 32'd0);
        checkVal("post_reset_rd2", rdA2, 32'd0);

        for (int i = 0; i < 100; i++)
            applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
